fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined RISC-V core.
- Holds the program counter and drives the instruction-memory address.
- Captures fetched words into the IF/ID pipeline register, which feeds the instruction parser in ID.
- Supports hazard-unit stall, EX-stage branch/jump redirect, and IF/ID flush (bubble insertion).

Parameters:
- XLEN, 32, datapath and PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0) placed in IF/ID on reset or flush.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard unit: hold PC and IF/ID contents.
- flush  input  1  force bubble into IF/ID at next edge.
- branch_taken  input  1  EX-stage redirect request.
- branch_target  input  XLEN  redirect address.
- imem_addr  output  XLEN  instruction-memory address; combinational from PC.
- imem_rdata  input  32  instruction word; combinational read of imem_addr, same cycle.
- if_id_pc  output  XLEN  PC of the instruction held in IF/ID.
- if_id_pc_plus4  output  XLEN  if_id_pc + 4.
- if_id_instruction  output  32  instruction word presented to ID/parser.
- if_id_valid  output  1  1 = real instruction; 0 = bubble.

Behaviour:
- All state updates on the rising edge of clk. Reset is synchronous, active-high, and has highest priority.
- Reset values:
  - pc = RESET_PC.
  - if_id_pc = 0, if_id_pc_plus4 = 0.
  - if_id_instruction = NOP_INSTR, if_id_valid = 0.
- imem_addr = pc at all times. Fetch latency is 1 cycle: a word addressed in cycle N appears on if_id_* after edge N.
- PC update, priority high to low:
  - reset -> RESET_PC.
  - branch_taken -> {branch_target[XLEN-1:2], 2'b00}. Redirect overrides stall.
  - stall -> hold.
  - else -> pc + 4, modulo 2^XLEN; 32'hFFFF_FFFC wraps to 0.
- IF/ID update, priority high to low:
  - reset -> bubble.
  - flush OR branch_taken -> bubble: instruction = NOP_INSTR, valid = 0, pc = 0, pc_plus4 = 0. Overrides stall.
  - stall -> hold all four fields.
  - else -> pc, pc + 4, imem_rdata, valid = 1.
- branch_taken implies an IF/ID flush even if flush = 0. The wrong-path word fetched that cycle is discarded.
- flush without branch_taken: IF/ID bubbles, and the PC follows the stall/normal rule.
- stall with flush (no branch): IF/ID bubbles, PC holds.
- Reset mid-operation: the next edge restores all reset values regardless of stall, flush or branch inputs.
- First edge after reset deasserts: IF/ID captures the word at RESET_PC with valid = 1.
- if_id_pc_plus4 is registered; it is not recomputed from if_id_pc. All arithmetic is unsigned XLEN-bit, with carries discarded.
- No combinational path from stall, flush or branch_* to if_id_*. The only combinational output is imem_addr (from pc).

Decomposition:
- Shared package core_pkg:
  - XLEN, RESET_PC, NOP_INSTR.
  - Opcode constants (OP_BRANCH, OP_JAL, ...) used by this stage, the parser and the control unit.
- One natural sub-module: if_id_reg.
  - Holds the IF/ID fields with clk, reset, stall and flush ports.
  - Reused pattern for the ID/EX, EX/MEM and MEM/WB registers.
- PC register and next-PC mux stay in fetch_stage.

Test Plan:
- Reset then 4 free-running cycles, imem word = 32'h1000_0000 | addr:
  - imem_addr steps 0, 4, 8, 12.
  - if_id_pc lags by one cycle; if_id_instruction = 32'h1000_0004 when if_id_pc = 4; if_id_valid = 1 from the first edge.
- Stall asserted 2 cycles with pc = 8:
  - imem_addr stays 8.
  - if_id_pc stays 4 and if_id_instruction stays unchanged.
  - Resumes 8, 12 after release.
- branch_taken with branch_target = 32'h0000_0103 while stall = 1:
  - Next edge: pc = 32'h0000_0100, if_id_valid = 0, if_id_instruction = 32'h0000_0013.
  - Following edge: if_id_pc = 32'h100.
- flush alone at pc = 16:
  - if_id_valid = 0 for one cycle; pc advances to 20.
  - Next if_id_pc = 20; no instruction is replayed.
- pc = 32'hFFFF_FFFC with no stall: next imem_addr = 0, and if_id_pc_plus4 = 0 for that instruction.
- reset asserted mid-stream together with stall and branch_taken:
  - Next edge: pc = RESET_PC, if_id_valid = 0, if_id_instruction = NOP_INSTR, if_id_pc = 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core constants, opcode encodings and pipeline-register payload types.
package core_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned ILEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC  = XLEN'(32'h0000_0000);
  localparam logic [ILEN-1:0] NOP_INSTR = ILEN'(32'h0000_0013);

  localparam logic [6:0] OP_LOAD   = 7'b000_0011;
  localparam logic [6:0] OP_IMM    = 7'b001_0011;
  localparam logic [6:0] OP_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OP_STORE  = 7'b010_0011;
  localparam logic [6:0] OP_REG    = 7'b011_0011;
  localparam logic [6:0] OP_LUI    = 7'b011_0111;
  localparam logic [6:0] OP_BRANCH = 7'b110_0011;
  localparam logic [6:0] OP_JALR   = 7'b110_0111;
  localparam logic [6:0] OP_JAL    = 7'b110_1111;
  localparam logic [6:0] OP_SYSTEM = 7'b111_0011;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [ILEN-1:0] instr;
    logic            valid;
  } if_id_t;

  localparam int unsigned IF_ID_W = $bits(if_id_t);

  localparam if_id_t IF_ID_BUBBLE = '{
    pc:       '0,
    pc_plus4: '0,
    instr:    NOP_INSTR,
    valid:    1'b0
  };

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register: reset/flush load a bubble, stall holds, otherwise capture.
module if_id_reg #(
  parameter int unsigned   W      = 1,
  parameter logic [W-1:0]  BUBBLE = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o
);

  logic [W-1:0] data_q;

  // Flush beats stall so a squashed slot never lingers during a hazard hold.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      data_q <= BUBBLE;
    end else if (!stall_i) begin
      data_q <= data_i;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection and the IF/ID pipeline register.
module fetch_stage
  import core_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4,
  output logic [ILEN-1:0] if_id_instruction,
  output logic            if_id_valid
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc_plus4;
  logic            flush_any;
  if_id_t          fetch_d;
  if_id_t          if_id_q;

  assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);

  // Redirect wins over stall; the target is forced word-aligned.
  always_comb begin
    pc_d = pc_q;
    if (branch_taken) begin
      pc_d = branch_target & ALIGN_MASK;
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr = pc_q;

  always_comb begin
    fetch_d          = IF_ID_BUBBLE;
    fetch_d.pc       = pc_q;
    fetch_d.pc_plus4 = pc_plus4;
    fetch_d.instr    = imem_rdata;
    fetch_d.valid    = 1'b1;
  end

  // A taken redirect squashes the wrong-path word fetched this cycle.
  assign flush_any = flush | branch_taken;

  if_id_reg #(
    .W      (IF_ID_W),
    .BUBBLE (IF_ID_BUBBLE)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .stall_i (stall),
    .flush_i (flush_any),
    .data_i  (fetch_d),
    .data_o  (if_id_q)
  );

  assign if_id_pc          = if_id_q.pc;
  assign if_id_pc_plus4    = if_id_q.pc_plus4;
  assign if_id_instruction = if_id_q.instr;
  assign if_id_valid       = if_id_q.valid;

endmodule
